// File: rtl/fmul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fmul_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } flags_t;

  // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in a wide vector.
  function automatic logic [127:0] qnan_bits(input int unsigned exp_w, input int unsigned mant_w);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) r[mant_w + i] = 1'b1;
    r[mant_w - 1] = 1'b1;
    return r;
  endfunction

  // Subnormals (exp=0) are flushed to zero.
  function automatic cls_t classify(input logic exp_zero, input logic exp_ones, input logic frac_nz);
    if (exp_zero)
      return CLS_ZERO;
    else if (exp_ones)
      return frac_nz ? CLS_NAN : CLS_INF;
    else
      return CLS_NORM;
  endfunction

  // Result class of a product in special-case priority order.
  function automatic cls_t combine(input cls_t a, input cls_t b);
    if (a == CLS_NAN || b == CLS_NAN ||
        (a == CLS_INF && b == CLS_ZERO) || (a == CLS_ZERO && b == CLS_INF))
      return CLS_NAN;
    else if (a == CLS_INF || b == CLS_INF)
      return CLS_INF;
    else if (a == CLS_ZERO || b == CLS_ZERO)
      return CLS_ZERO;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational normalise, round-to-nearest-even and pack for the final stage.
// Optional FMUL_FLAGS_EN adds the {nv, of, uf, nx} flag output.
module fmul_round
  import fmul_pkg::*;
#(
  parameter int unsigned EXP  = 8,
  parameter int unsigned MANT = 23
) (
  input  logic                    sign,
  input  cls_t                    cls,
  input  logic signed [EXP+1:0]   exp,
  input  logic [2*MANT+1:0]       prod,
`ifdef FMUL_FLAGS_EN
  output flags_t                  flags,
`endif
  output logic [EXP+MANT:0]       c
);

  localparam logic [127:0] QNAN_FULL = qnan_bits(EXP, MANT);
  localparam logic signed [EXP+1:0] EXP_MAX = $signed({2'b00, {EXP{1'b1}}});

  logic                  msb;
  logic [2*MANT:0]       norm;
  logic [MANT-1:0]       frac_n;
  logic                  guard;
  logic                  sticky;
  logic                  inc;
  logic [MANT:0]         frac_sum;
  logic signed [EXP+1:0] exp_n;
  logic signed [EXP+1:0] exp_r;

  always_comb begin
    msb      = prod[2*MANT+1];
    // Drop the leading one: a product in [2,4) loses its MSB, [1,2) is shifted up.
    norm     = msb ? prod[2*MANT:0] : {prod[2*MANT-1:0], 1'b0};
    frac_n   = norm[2*MANT:MANT+1];
    guard    = norm[MANT];
    sticky   = |norm[MANT-1:0];
    inc      = guard & (sticky | frac_n[0]);
    frac_sum = {1'b0, frac_n} + (MANT+1)'(inc);
    exp_n    = exp + $signed({{(EXP+1){1'b0}}, msb});
    exp_r    = exp_n + $signed({{(EXP+1){1'b0}}, frac_sum[MANT]});

    c = '0;
`ifdef FMUL_FLAGS_EN
    flags = '0;
`endif
    case (cls)
      CLS_NAN: begin
        c = QNAN_FULL[EXP+MANT:0];
`ifdef FMUL_FLAGS_EN
        flags.nv = 1'b1;
`endif
      end
      CLS_INF:  c = {sign, {EXP{1'b1}}, {MANT{1'b0}}};
      CLS_ZERO: c = {sign, {(EXP+MANT){1'b0}}};
      default: begin
        if (exp_r >= EXP_MAX) begin
          c = {sign, {EXP{1'b1}}, {MANT{1'b0}}};
`ifdef FMUL_FLAGS_EN
          flags.of = 1'b1;
`endif
        end else if (exp_r[EXP+1] || exp_r == '0) begin
          c = {sign, {(EXP+MANT){1'b0}}};
`ifdef FMUL_FLAGS_EN
          flags.uf = 1'b1;
`endif
        end else begin
          c = {sign, exp_r[EXP-1:0], frac_sum[MANT-1:0]};
        end
`ifdef FMUL_FLAGS_EN
        flags.nx = guard | sticky | flags.of | flags.uf;
`endif
      end
    endcase
  end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Define FMUL_FLAGS_EN to add the pipelined flags_o exception port.
module fmul_pipe
  import fmul_pkg::*;
#(
  parameter int unsigned EXP  = 8,
  parameter int unsigned MANT = 23,
  parameter int unsigned BIAS = (1 << (EXP - 1)) - 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [EXP+MANT:0]   a_i,
  input  logic [EXP+MANT:0]   b_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [EXP+MANT:0]   c_o,
  output logic                valid_o,
`ifdef FMUL_FLAGS_EN
  output logic [3:0]          flags_o,
`endif
  input  logic                ready_i
);

  localparam logic [EXP+1:0] BIAS_V = (EXP+2)'(BIAS);

  logic                  s1_valid, s2_valid;
  logic                  s1_adv, s2_adv, in_fire;

  logic                  s1_sign;
  logic signed [EXP+1:0] s1_exp;
  cls_t                  s1_cls;
  logic [MANT:0]         s1_ma, s1_mb;

  logic                  s2_sign;
  logic signed [EXP+1:0] s2_exp;
  cls_t                  s2_cls;
  logic [2*MANT+1:0]     s2_prod;

  cls_t                  cls_a, cls_b;
  logic [EXP+1:0]        exp_sum;
  logic [EXP+MANT:0]     c_next;
`ifdef FMUL_FLAGS_EN
  flags_t                flags_next;
`endif

  // Stall chain runs back from ready_i so a full pipe still moves one per cycle.
  always_comb begin
    s2_adv  = s2_valid && (!valid_o || ready_i);
    s1_adv  = s1_valid && (!s2_valid || s2_adv);
    ready_o = !s1_valid || s1_adv;
    in_fire = valid_i && ready_o;
  end

  always_comb begin
    cls_a   = classify(a_i[MANT +: EXP] == '0, a_i[MANT +: EXP] == '1, a_i[MANT-1:0] != '0);
    cls_b   = classify(b_i[MANT +: EXP] == '0, b_i[MANT +: EXP] == '1, b_i[MANT-1:0] != '0);
    exp_sum = (EXP+2)'(a_i[MANT +: EXP]) + (EXP+2)'(b_i[MANT +: EXP]) - BIAS_V;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      valid_o  <= 1'b0;
      c_o      <= '0;
`ifdef FMUL_FLAGS_EN
      flags_o  <= '0;
`endif
    end else begin
      if (ready_o)
        s1_valid <= valid_i;
      if (!s2_valid || s2_adv)
        s2_valid <= s1_valid;
      if (!valid_o || ready_i)
        valid_o <= s2_valid;
      if (s2_adv) begin
        c_o     <= c_next;
`ifdef FMUL_FLAGS_EN
        flags_o <= flags_next;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      s1_sign <= a_i[EXP+MANT] ^ b_i[EXP+MANT];
      s1_exp  <= $signed(exp_sum);
      s1_cls  <= combine(cls_a, cls_b);
      s1_ma   <= {1'b1, a_i[MANT-1:0]};
      s1_mb   <= {1'b1, b_i[MANT-1:0]};
    end
    if (s1_adv) begin
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_cls  <= s1_cls;
      s2_prod <= (2*MANT+2)'(s1_ma) * (2*MANT+2)'(s1_mb);
    end
  end

  fmul_round #(
    .EXP  (EXP),
    .MANT (MANT)
  ) u_round (
    .sign  (s2_sign),
    .cls   (s2_cls),
    .exp   (s2_exp),
    .prod  (s2_prod),
`ifdef FMUL_FLAGS_EN
    .flags (flags_next),
`endif
    .c     (c_next)
  );

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed-vector bench for fmul_pipe (binary32); flag checks only with FMUL_FLAGS_EN.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, valid_o, ready_i;
  logic [31:0] a_i, b_i, c_o;
`ifdef FMUL_FLAGS_EN
  logic [3:0]  flags_o;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  fmul_pipe #(
    .EXP  (8),
    .MANT (23)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .c_o     (c_o),
    .valid_o (valid_o),
`ifdef FMUL_FLAGS_EN
    .flags_o (flags_o),
`endif
    .ready_i (ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  localparam int NV = 15;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [31:0] vc [NV];
  logic [3:0]  vf [NV];   // {nv, of, uf, nx}

  task automatic single(input int idx);
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    a_i = va[idx]; b_i = vb[idx]; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " c"}, c_o, vc[idx]);
`ifdef FMUL_FLAGS_EN
    check({tag, " flags"}, {28'd0, flags_o}, {28'd0, vf[idx]});
`endif
    @(posedge clk); #1;
    check({tag, " valid pulse"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int  sent, got, outs;
    bit  held_v, saw_low, in_f, out_f;
    logic [31:0] held;

    va = '{32'h40400000, 32'h3FC00000, 32'h7F000000, 32'hFF000000, 32'h7F800000,
           32'h80000000, 32'h7FC00001, 32'h00800000, 32'h3F800000, 32'hC0000000,
           32'hFF800000, 32'h3FCA6691, 32'h00800000, 32'h00800000, 32'h00400000};
    vb = '{32'h40200000, 32'h3F800001, 32'h7F000000, 32'h7F000000, 32'h00000000,
           32'h40400000, 32'h3F800000, 32'h00800000, 32'h3F800000, 32'h40400000,
           32'h40000000, 32'h3FA1E58F, 32'h3F800000, 32'h3F000000, 32'h40000000};
    vc = '{32'h40F00000, 32'h3FC00002, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
           32'h80000000, 32'h7FC00000, 32'h00000000, 32'h3F800000, 32'hC0C00000,
           32'hFF800000, 32'h40000000, 32'h00800000, 32'h00000000, 32'h00000000};
    vf = '{4'b0000, 4'b0001, 4'b0101, 4'b0101, 4'b1000,
           4'b0000, 4'b1000, 4'b0011, 4'b0000, 4'b0000,
           4'b0000, 4'b0001, 4'b0000, 4'b0011, 4'b0000};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid_o", {31'd0, valid_o}, 32'd0);
    check("reset c_o", c_o, 32'd0);
    check("reset ready_o", {31'd0, ready_o}, 32'd1);
`ifdef FMUL_FLAGS_EN
    check("reset flags", {28'd0, flags_o}, 32'd0);
`endif
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < NV; i++) single(i);

    // Six back-to-back operations with the output stalled on cycles 3..6.
    sent = 0; got = 0; held_v = 1'b0; saw_low = 1'b0; held = '0;
    for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
      @(negedge clk);
      ready_i = !(cyc >= 3 && cyc <= 6);
      if (sent < 6) begin
        valid_i = 1'b1; a_i = va[sent]; b_i = vb[sent];
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (held_v) check("stall hold", c_o, held);
      held_v = valid_o && !ready_i;
      held   = c_o;
      if (!ready_o) saw_low = 1'b1;
      in_f  = valid_i && ready_o;
      out_f = valid_o && ready_i;
      if (out_f) begin
        check($sformatf("stream%0d", got), c_o, vc[got]);
        got++;
      end
      @(posedge clk);
      if (in_f) sent++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("stream count", 32'(got), 32'd6);
    check("ready_o drop", {31'd0, saw_low}, 32'd1);
    @(negedge clk);
    check("stream drained", {31'd0, valid_o}, 32'd0);

    // Reset with two operations in flight.
    @(negedge clk);
    a_i = va[0]; b_i = vb[0]; valid_i = 1'b1;
    @(negedge clk);
    a_i = va[9]; b_i = vb[9];
    @(negedge clk);
    valid_i = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1;
    check("flush valid_o", {31'd0, valid_o}, 32'd0);
    check("flush c_o", c_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    outs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid_o) outs++;
    end
    check("flush no output", 32'(outs), 32'd0);
    check("flush ready_o", {31'd0, ready_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
